// File: rtl/ahb_arb2.sv
// Two-master AHB arbiter and address/data multiplexer.
// Grant is registered; address and write-data muxes follow the AHB pipeline.
module ahb_arb2 #(
    parameter int DEFAULT_MASTER = 0,
    parameter int RR_EN          = 1
) (
    input  logic        hclk,
    input  logic        rst_i,
    input  logic [31:0] m0_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic        m0_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [2:0]  m0_hburst,
    input  logic [31:0] m0_hwdata,
    input  logic        m0_hbusreq,
    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m1_htrans,
    input  logic        m1_hwrite,
    input  logic [2:0]  m1_hsize,
    input  logic [2:0]  m1_hburst,
    input  logic [31:0] m1_hwdata,
    input  logic        m1_hbusreq,
    output logic        m0_hgrant,
    output logic        m1_hgrant,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    output logic        hmaster,
    input  logic        hready
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam logic PARK = 1'(DEFAULT_MASTER);

    logic       grant;
    logic       grant_nxt;
    logic       hmaster_d;
    logic [3:0] beats_rem;
    logic [3:0] beats_nxt;
    logic       burst_start;
    logic       arb_point;

    // Address-phase signals come from the current bus owner.
    always_comb begin
        haddr  = hmaster ? m1_haddr  : m0_haddr;
        htrans = hmaster ? m1_htrans : m0_htrans;
        hwrite = hmaster ? m1_hwrite : m0_hwrite;
        hsize  = hmaster ? m1_hsize  : m0_hsize;
        hburst = hmaster ? m1_hburst : m0_hburst;
    end

    // Write data follows the owner of the previous address phase.
    always_comb begin
        hwdata = hmaster_d ? m1_hwdata : m0_hwdata;
    end

    assign m0_hgrant = ~grant;
    assign m1_hgrant = grant;

    // A NONSEQ of a fixed-length burst locks the bus for its whole length.
    assign burst_start = (htrans == NONSEQ) && (hburst[2:1] != 2'b00);
    assign arb_point   = hready && (beats_rem == 4'd0) && !burst_start;

    // Pick the next grant; only re-arbitrate at an arbitration point.
    always_comb begin
        grant_nxt = grant;
        if (arb_point) begin
            unique case ({m1_hbusreq, m0_hbusreq})
                2'b00: grant_nxt = PARK;
                2'b01: grant_nxt = 1'b0;
                2'b10: grant_nxt = 1'b1;
                2'b11: grant_nxt = (RR_EN != 0) ? ~grant : 1'b1;
            endcase
        end
    end

    // Track beats left in a fixed-length burst; NONSEQ always restarts it.
    always_comb begin
        beats_nxt = beats_rem;
        if (htrans == NONSEQ) begin
            unique case (hburst[2:1])
                2'b01:   beats_nxt = 4'd3;
                2'b10:   beats_nxt = 4'd7;
                2'b11:   beats_nxt = 4'd15;
                default: beats_nxt = 4'd0;
            endcase
        end else if (htrans == SEQ && beats_rem != 4'd0) begin
            beats_nxt = beats_rem - 4'd1;
        end
    end

    // Pipeline state advances only when the slave accepts the transfer.
    always_ff @(posedge hclk or posedge rst_i) begin
        if (rst_i) begin
            grant     <= PARK;
            hmaster   <= PARK;
            hmaster_d <= PARK;
            beats_rem <= 4'd0;
        end else if (hready) begin
            grant     <= grant_nxt;
            hmaster   <= grant;
            hmaster_d <= hmaster;
            beats_rem <= beats_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_arb2.sv
// Randomized bench for ahb_arb2: two instances (round-robin/park 0 and
// fixed-priority/park 1) checked against a transaction-level model.
module tb_ahb_arb2;

    localparam int RR [2] = '{1, 0};
    localparam int DM [2] = '{0, 1};

    logic        hclk;
    logic        rst_i;
    logic        hready;
    logic [31:0] addr   [2];
    logic [1:0]  trans  [2];
    logic        write  [2];
    logic [2:0]  size   [2];
    logic [2:0]  burst  [2];
    logic [31:0] wdata  [2];
    logic        busreq [2];

    logic        g0     [2];
    logic        g1     [2];
    logic [31:0] o_addr [2];
    logic [1:0]  o_trans[2];
    logic        o_write[2];
    logic [2:0]  o_size [2];
    logic [2:0]  o_burst[2];
    logic [31:0] o_wdata[2];
    logic        o_mst  [2];

    int m_grant [2];
    int m_own   [2];
    int m_down  [2];
    int m_rem   [2];

    int n_cmp;
    int n_bad;

    ahb_arb2 #(.DEFAULT_MASTER(0), .RR_EN(1)) u_a (
        .hclk(hclk), .rst_i(rst_i),
        .m0_haddr(addr[0]), .m0_htrans(trans[0]), .m0_hwrite(write[0]),
        .m0_hsize(size[0]), .m0_hburst(burst[0]), .m0_hwdata(wdata[0]),
        .m0_hbusreq(busreq[0]),
        .m1_haddr(addr[1]), .m1_htrans(trans[1]), .m1_hwrite(write[1]),
        .m1_hsize(size[1]), .m1_hburst(burst[1]), .m1_hwdata(wdata[1]),
        .m1_hbusreq(busreq[1]),
        .m0_hgrant(g0[0]), .m1_hgrant(g1[0]),
        .haddr(o_addr[0]), .htrans(o_trans[0]), .hwrite(o_write[0]),
        .hsize(o_size[0]), .hburst(o_burst[0]), .hwdata(o_wdata[0]),
        .hmaster(o_mst[0]), .hready(hready)
    );

    ahb_arb2 #(.DEFAULT_MASTER(1), .RR_EN(0)) u_b (
        .hclk(hclk), .rst_i(rst_i),
        .m0_haddr(addr[0]), .m0_htrans(trans[0]), .m0_hwrite(write[0]),
        .m0_hsize(size[0]), .m0_hburst(burst[0]), .m0_hwdata(wdata[0]),
        .m0_hbusreq(busreq[0]),
        .m1_haddr(addr[1]), .m1_htrans(trans[1]), .m1_hwrite(write[1]),
        .m1_hsize(size[1]), .m1_hburst(burst[1]), .m1_hwdata(wdata[1]),
        .m1_hbusreq(busreq[1]),
        .m0_hgrant(g0[1]), .m1_hgrant(g1[1]),
        .haddr(o_addr[1]), .htrans(o_trans[1]), .hwrite(o_write[1]),
        .hsize(o_size[1]), .hburst(o_burst[1]), .hwdata(o_wdata[1]),
        .hmaster(o_mst[1]), .hready(hready)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Burst length in beats: SINGLE/INCR count as one, else 4/8/16.
    function automatic int blen(input int b);
        return (b < 2) ? 1 : (2 << (b >> 1));
    endfunction

    function automatic int pick(input int c);
        if (busreq[0] && busreq[1])
            return RR[c] ? 1 - m_grant[c] : 1;
        if (busreq[0]) return 0;
        if (busreq[1]) return 1;
        return DM[c];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_grant[c] = DM[c];
            m_own[c]   = DM[c];
            m_down[c]  = DM[c];
            m_rem[c]   = 0;
        end
    endtask

    task automatic model_edge();
        int o, t, b, ng, nr;
        bit locked;
        if (rst_i || !hready) return;
        for (int c = 0; c < 2; c++) begin
            o = m_own[c];
            t = int'(trans[o]);
            b = int'(burst[o]);
            locked = (m_rem[c] > 0) || (t == 2 && b >= 2);
            ng = locked ? m_grant[c] : pick(c);
            nr = m_rem[c];
            if (t == 2) nr = blen(b) - 1;
            else if (t == 3 && nr > 0) nr = nr - 1;
            m_down[c]  = m_own[c];
            m_own[c]   = m_grant[c];
            m_grant[c] = ng;
            m_rem[c]   = nr;
        end
    endtask

    task automatic check_all();
        int o, d;
        for (int c = 0; c < 2; c++) begin
            o = m_own[c];
            d = m_down[c];
            chk($sformatf("d%0d_m0_hgrant", c), 32'(g0[c]),
                32'(m_grant[c] == 0));
            chk($sformatf("d%0d_m1_hgrant", c), 32'(g1[c]),
                32'(m_grant[c] == 1));
            chk($sformatf("d%0d_hmaster", c), 32'(o_mst[c]), 32'(o));
            chk($sformatf("d%0d_haddr", c), o_addr[c], addr[o]);
            chk($sformatf("d%0d_htrans", c), 32'(o_trans[c]),
                32'(trans[o]));
            chk($sformatf("d%0d_hwrite", c), 32'(o_write[c]),
                32'(write[o]));
            chk($sformatf("d%0d_hsize", c), 32'(o_size[c]), 32'(size[o]));
            chk($sformatf("d%0d_hburst", c), 32'(o_burst[c]),
                32'(burst[o]));
            chk($sformatf("d%0d_hwdata", c), o_wdata[c], wdata[d]);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        model_edge();
        @(negedge hclk);
        check_all();
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic rst_pulse();
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst_i = 1'b0;
    endtask

    task automatic set_m(input int m, input logic [1:0] t,
                         input logic [2:0] b, input logic rq);
        trans[m]  = t;
        burst[m]  = b;
        busreq[m] = rq;
        addr[m]   = $urandom;
        wdata[m]  = $urandom;
        write[m]  = 1'($urandom);
        size[m]   = 3'($urandom_range(0, 2));
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_i  = 1'b1;
        hready = 1'b1;
        set_m(0, 2'b10, 3'b000, 1'b0);
        set_m(1, 2'b11, 3'b000, 1'b0);
        #2;
        model_reset();
        check_all();
        chk("rst_m0_hgrant", 32'(g0[0]), 32'd1);
        chk("rst_m1_hgrant", 32'(g1[0]), 32'd0);
        chk("rst_hmaster", 32'(o_mst[0]), 32'd0);
        chk("rst_htrans", 32'(o_trans[0]), 32'd2);

        @(negedge hclk);
        rst_i = 1'b0;
        set_m(0, 2'b00, 3'b000, 1'b0);
        set_m(1, 2'b00, 3'b000, 1'b1);
        step();
        chk("sr_m1_hgrant", 32'(g1[0]), 32'd1);
        step();
        chk("sr_hmaster", 32'(o_mst[0]), 32'd1);
        step();
        chk("sr_hwdata", o_wdata[0], wdata[1]);

        set_m(0, 2'b00, 3'b000, 1'b1);
        set_m(1, 2'b10, 3'b011, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("lock_beat%0d", i), 32'(g1[0]), 32'd1);
            set_m(1, 2'b11, 3'b011, 1'b1);
        end
        set_m(1, 2'b00, 3'b000, 1'b1);
        step();
        chk("lock_release", 32'(g0[0]), 32'd1);

        set_m(0, 2'b00, 3'b000, 1'b0);
        step();
        step();
        set_m(1, 2'b10, 3'b101, 1'b1);
        set_m(0, 2'b00, 3'b000, 1'b1);
        step();
        set_m(1, 2'b11, 3'b101, 1'b1);
        step();
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            busreq[0] = 1'(i);
            busreq[1] = 1'(~i);
            wdata[0]  = $urandom;
            step();
            chk($sformatf("wait_grant%0d", i), 32'(g1[0]), 32'd1);
            chk($sformatf("wait_mst%0d", i), 32'(o_mst[0]), 32'd1);
        end
        hready = 1'b1;
        set_m(0, 2'b00, 3'b000, 1'b1);
        step();
        chk("resume_grant", 32'(g1[0]), 32'd1);
        rst_pulse();
        chk("midrst_m0_hgrant", 32'(g0[0]), 32'd1);
        chk("midrst_hmaster", 32'(o_mst[0]), 32'd0);

        set_m(0, 2'b10, 3'b000, 1'b1);
        set_m(1, 2'b10, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rr_%0d", i), 32'(g1[0]), 32'((i + 1) % 2));
            chk($sformatf("fp_%0d", i), 32'(g1[1]), 32'd1);
        end

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) rst_pulse();
            for (int m = 0; m < 2; m++)
                set_m(m, 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
            hready = ($urandom_range(0, 4) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
